// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the memory port arbiter and its owner FIFO.
package mem_port_arbiter_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam int DEFAULT_DEPTH = 2;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic owner;
    logic discard;
  } owner_ent_t;

endpackage

// File: rtl/mem_port_arbiter_arb_owner_fifo.sv
// In-order FIFO of {owner, discard} for outstanding bus transactions; head visible same cycle.
// Push ignored when full, pop ignored when empty; i_cancel marks every stored inst entry discarded.
module arb_owner_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  owner_ent_t i_push_ent,
  input  logic       i_pop,
  input  logic       i_cancel,
  output logic       o_full,
  output logic       o_empty,
  output owner_ent_t o_head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  owner_ent_t     r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // Stale slots may also get flagged; they are rewritten on their next push.
      for (int i = 0; i < DEPTH; i++) begin
        if (i_cancel && r_mem[i].owner == OWNER_INST) begin
          r_mem[i].discard <= 1'b1;
        end
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_ent;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; zero-latency address mux, responses routed via owner FIFO.
// Stalls both requesters while DEPTH transactions are outstanding; MEM_ARB_RR_EN selects round-robin over data priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_cancel,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  logic       w_grant;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  owner_ent_t w_push_ent;
  owner_ent_t w_head;

`ifdef MEM_ARB_RR_EN
  logic r_rr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= OWNER_INST;
    end else if (w_push) begin
      r_rr_ptr <= ~w_grant;
    end
  end

  assign w_grant = (data_req && (!inst_req || r_rr_ptr == OWNER_DATA)) ? OWNER_DATA : OWNER_INST;
`else
  assign w_grant = data_req ? OWNER_DATA : OWNER_INST;
`endif

  // No bypass when full: a same-cycle pop does not free a slot until the next cycle.
  assign mem_req = (inst_req | data_req) & ~w_full & ~reset;
  assign w_push  = mem_req & mem_addr_ok;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = SIZE_WORD;
    mem_wstrb = 4'h0;
    mem_addr  = inst_addr;
    mem_wdata = 32'h0;
    if (w_grant == OWNER_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wr ? data_wstrb : 4'h0;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  assign inst_addr_ok = w_push & (w_grant == OWNER_INST);
  assign data_addr_ok = w_push & (w_grant == OWNER_DATA);

  assign w_push_ent.owner   = w_grant;
  assign w_push_ent.discard = (w_grant == OWNER_INST) & inst_cancel;

  arb_owner_fifo #(
    .DEPTH(DEPTH)
  ) u_owner_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_ent (w_push_ent),
    .i_pop      (w_pop),
    .i_cancel   (inst_cancel),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (w_head)
  );

  assign w_pop        = mem_data_ok & ~w_empty & ~reset;
  assign inst_data_ok = w_pop & (w_head.owner == OWNER_INST) & ~w_head.discard;
  assign data_data_ok = w_pop & (w_head.owner == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter in the default (fixed data priority) build, DEPTH = 2.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_cancel;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_cancel  (inst_cancel),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    inst_cancel = 1'b0;
    inst_req    = 1'b0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_wstrb  = 4'h0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    inst_addr  = 32'h0;
    data_size  = 2'd2;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    mem_rdata  = 32'h0;
    idle();

    // Handshakes forced low during reset even with every input active
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    samp();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    chk("rst_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("rst_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    tick(); tick();
    reset = 1'b0; idle();
    tick();

    // Single fetch, response three cycles later
    inst_req = 1'b1; inst_addr = 32'hBFC00000; mem_addr_ok = 1'b1;
    samp();
    chk("f1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("f1_mem_addr", mem_addr, 32'hBFC00000);
    chk("f1_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("f1_mem_size", {30'd0, mem_size}, 32'd2);
    chk("f1_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("f1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("f1_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    tick(); idle();
    samp(); chk("f1_wait1_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    tick();
    samp(); chk("f1_wait2_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h3C1D0000;
    samp();
    chk("f1_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("f1_inst_rdata", inst_rdata, 32'h3C1D0000);
    chk("f1_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    tick(); idle();

    // Both requesting: data wins twice, then the FIFO is full
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80001000; data_wstrb = 4'hF;
    mem_addr_ok = 1'b1;
    samp();
    chk("arb1_mem_addr", mem_addr, 32'h80001000);
    chk("arb1_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("arb1_read_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("arb1_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("arb1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    tick();
    samp();
    chk("arb2_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("arb2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'hAAAA0001;
    samp();
    chk("full_mem_req", {31'd0, mem_req}, 32'd0);
    chk("full_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    chk("full_pop_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("full_pop_data_rdata", data_rdata, 32'hAAAA0001);
    tick();
    mem_data_ok = 1'b0; data_req = 1'b0;
    samp();
    chk("refill_mem_req", {31'd0, mem_req}, 32'd1);
    chk("refill_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("refill_mem_addr", mem_addr, 32'hBFC00004);
    tick(); idle();
    mem_data_ok = 1'b1; mem_rdata = 32'hAAAA0002;
    samp();
    chk("drain1_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("drain1_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    tick();
    mem_rdata = 32'hAAAA0003;
    samp();
    chk("drain2_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("drain2_inst_rdata", inst_rdata, 32'hAAAA0003);
    chk("drain2_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    tick(); idle();

    // Fetch read followed by a data write; responses return in order
    inst_req = 1'b1; inst_addr = 32'hBFC00010; mem_addr_ok = 1'b1;
    samp(); chk("ord_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    tick();
    inst_req = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 32'h80002000; data_wdata = 32'h12345678;
    samp();
    chk("wr_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("wr_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("wr_mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
    chk("wr_mem_wdata", mem_wdata, 32'h12345678);
    chk("wr_mem_addr", mem_addr, 32'h80002000);
    chk("wr_mem_size", {30'd0, mem_size}, 32'd2);
    tick(); idle();
    mem_data_ok = 1'b1; mem_rdata = 32'h11111111;
    samp();
    chk("ord1_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("ord1_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    tick();
    samp();
    chk("ord2_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("ord2_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    tick(); idle();

    // Cancel with a fetch outstanding drops it; a later fetch returns normally
    inst_req = 1'b1; inst_addr = 32'hBFC00020; mem_addr_ok = 1'b1;
    tick(); idle();
    inst_cancel = 1'b1;
    tick(); idle();
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD0001;
    samp(); chk("cancel_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    tick(); idle();
    inst_req = 1'b1; inst_addr = 32'hBFC00024; mem_addr_ok = 1'b1;
    samp(); chk("post_cancel_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    tick(); idle();
    mem_data_ok = 1'b1; mem_rdata = 32'h600D0001;
    samp();
    chk("post_cancel_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("post_cancel_inst_rdata", inst_rdata, 32'h600D0001);
    tick(); idle();

    // Cancel leaves an outstanding data read alone
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80003000; mem_addr_ok = 1'b1;
    tick(); idle();
    inst_cancel = 1'b1;
    tick(); idle();
    mem_data_ok = 1'b1; mem_rdata = 32'h0DA7A000;
    samp(); chk("cancel_keeps_data", {31'd0, data_data_ok}, 32'd1);
    tick(); idle();

    // Fetch accepted in the cancel cycle is dropped; spurious data_ok while empty is ignored
    inst_req = 1'b1; inst_addr = 32'hBFC00030; mem_addr_ok = 1'b1; inst_cancel = 1'b1;
    samp(); chk("samecyc_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    tick(); idle();
    mem_data_ok = 1'b1;
    samp(); chk("samecyc_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    tick();
    samp();
    chk("empty_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("empty_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    tick(); idle();
    // Count must still be 0: exactly two accepts before stalling
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    samp(); chk("cnt_acc1", {31'd0, inst_addr_ok}, 32'd1);
    tick();
    samp(); chk("cnt_acc2", {31'd0, inst_addr_ok}, 32'd1);
    tick();
    samp(); chk("cnt_full_mem_req", {31'd0, mem_req}, 32'd0);
    tick(); idle();

    // Reset with transactions outstanding drops them
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_data_ok = 1'b1;
    samp();
    chk("post_rst_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("post_rst_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    tick(); idle();
    inst_req = 1'b1;
    samp(); chk("post_rst_mem_req", {31'd0, mem_req}, 32'd1);
    tick(); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory port between the fetch requester (inst) and the load/store requester (data).
- Sits between the pipeline stages and the external bus bridge.
- Arbitrates address-phase requests and tracks outstanding transactions in an in-order owner FIFO.
- Routes each data_ok/rdata response back to the requester that issued it; fetch responses made stale by a pipeline flush are dropped.

Parameters:
- DEPTH, 2, maximum outstanding (address accepted, data not yet returned) transactions; integer ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- inst_cancel  in  1  pulse: discard every outstanding fetch response
- inst_req  in  1  fetch request valid
- inst_addr  in  32  fetch byte address (read-only, size fixed 2'd2)
- inst_addr_ok  out  1  fetch address accepted this cycle
- inst_data_ok  out  1  fetch data returned this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  data request valid
- data_wr  in  1  1 = write
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte enables for writes
- data_addr  in  32  data byte address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data response (read data or write ack)
- data_rdata  out  32  read data
- mem_req  out  1  bus request
- mem_wr  out  1  bus write
- mem_size  out  2  bus size
- mem_wstrb  out  4  bus byte enables (0 for reads)
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_addr_ok  in  1  bus accepted address
- mem_data_ok  in  1  bus response valid
- mem_rdata  in  32  bus read data

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. Owner FIFO empties, count = 0, RR pointer = inst. While reset is high, all handshake outputs (mem_req, *_addr_ok, *_data_ok) are 0.
- FIFO entry: {owner (0 = inst, 1 = data), discard}. Count width is clog2(DEPTH+1).
- Arbitration:
  - grant is combinational, evaluated every cycle from the current request lines.
  - Only one requester: it wins.
  - Both requesting: data wins (fixed priority; see Optional Feature).
- Address phase (zero latency, combinational):
  - mem_req = (inst_req | data_req) & !full.
  - mem_* fields are muxed from the granted requester. For an inst grant: mem_wr = 0, mem_size = 2, mem_wstrb = 0.
  - inst_addr_ok = mem_req & mem_addr_ok & grant==inst. data_addr_ok likewise for data.
  - The ungranted requester sees addr_ok = 0 and must hold its request.
- Push: when mem_req & mem_addr_ok, push {grant, discard}. discard = 1 only if grant==inst and inst_cancel is high this cycle.
- Response phase:
  - mem_data_ok pops the FIFO head.
  - Head owner inst, discard = 0: inst_data_ok = 1, inst_rdata = mem_rdata.
  - Head owner inst, discard = 1: pop silently, no response.
  - Head owner data: data_data_ok = 1, data_rdata = mem_rdata.
  - Non-selected data_ok is 0. rdata outputs always carry mem_rdata (qualified only by data_ok).
- Cancel: when inst_cancel is high, every valid inst entry gets discard = 1, including the entry pushed that same cycle. Data entries are never discarded.
- Boundaries:
  - full (count == DEPTH): mem_req = 0, even if a pop occurs the same cycle. This is decided: no bypass.
  - Simultaneous push and pop when not full: count unchanged, and order is preserved.
  - mem_data_ok while empty is a protocol error: ignored, no pop, no data_ok output, count stays 0.
  - Responses return strictly in address-accept order; the FIFO read/write pointers wrap modulo DEPTH.
  - reset mid-transaction: all outstanding entries are dropped, and no responses are forwarded afterwards until new pushes.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. A 1-bit pointer names the preferred requester when both request. After a data address acceptance the pointer moves to inst; after an inst acceptance it moves to data. Reset value is inst.
- Undefined: fixed data priority, and no pointer register exists.

Decomposition:
- Shared package/header: owner encodings OWNER_INST = 1'b0, OWNER_DATA = 1'b1; SIZE_BYTE/HALF/WORD; default DEPTH.
- One sub-module, arb_owner_fifo: in-order FIFO of {owner, discard} with push, pop, full, empty, a head output, and a broadcast "set discard on all inst entries" input.
- Arbitration and muxing stay in the top module.

Test Plan:
- inst_req alone, addr 0xBFC00000, mem_addr_ok immediately, mem_data_ok 3 cycles later with rdata 0x3C1D0000 -> inst_addr_ok in cycle 0; inst_data_ok = 1 with inst_rdata = 0x3C1D0000 in cycle 3; data_data_ok stays 0.
- inst_req and data_req both held, data load at 0x80001000 -> data granted first (mem_addr = 0x80001000, mem_wr = 0). With MEM_ARB_RR_EN, inst granted next; without it, data keeps winning while data_req stays high.
- DEPTH = 2: two accepted reads, no mem_data_ok -> mem_req = 0 on the third cycle despite requests. A pop in the same cycle still keeps mem_req = 0; mem_req reasserts the cycle after.
- Issue inst read, then data write (wstrb 0xF, wdata 0x12345678); responses in order -> first mem_data_ok goes to inst, second raises data_data_ok. The write bus fields match the data inputs.
- Inst read outstanding, inst_cancel pulse, then mem_data_ok -> no inst_data_ok. A new inst read after the cancel returns normally.
- Inst read accepted in the same cycle as inst_cancel -> its response is dropped. mem_data_ok while empty -> no outputs, count stays 0.
